mips_multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. Decodes the 6-bit instruction opcode and sequences the datapath one phase per cycle. Drives every datapath enable and mux select, plus the 2-bit `ALUop` consumed by the ALU control unit, which maps `ALUop` and the function field to the 3-bit ALU select. Stalls on a single-bit memory-ready handshake.

---
 rtl/mips_multicycle_control_pkg.sv | 36 +++
 rtl/mips_multicycle_control_if.sv | 39 +++
 rtl/mips_multicycle_control_opcode_decode.sv | 29 ++
 rtl/mips_multicycle_control.sv | 133 +++++++++++++
 tb/tb_mips_multicycle_control.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS control path.
//   - opcode constants (instruction bits [31:26])
//   - ALUop encodings, also consumed by the ALU control unit
//   - 4-bit main-control state encoding
// Configuration: MIPS_JUMP_EN adds the JUMP state.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
`ifdef MIPS_JUMP_EN
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
`else
    S_BRANCH    = 4'd9
`endif
  } state_e;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: control bundle between the main control FSM
// and the datapath/memory.
//   inputs to the FSM : opcode[5:0], mem_ready
//   outputs of the FSM: datapath enables/selects, ALUop[1:0], illegal_op,
//                       state[3:0] (debug)
// modport master: the control FSM; modport slave: datapath/memory side.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop,
           illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control_opcode_decode.sv
// mips_opcode_decode: combinational opcode classifier for the main control.
//   opcode[5:0] in; class flags out (is_mem covers lw and sw, is_lw picks lw).
// Configuration: without MIPS_JUMP_EN, opcode 000010 classifies as illegal.
module mips_opcode_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_mem,
  output logic       is_lw,
  output logic       is_rtype,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_illegal
);

  always_comb begin
    is_lw    = (opcode == OP_LW);
    is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    is_rtype = (opcode == OP_RTYPE);
    is_beq   = (opcode == OP_BEQ);
`ifdef MIPS_JUMP_EN
    is_j     = (opcode == OP_J);
`else
    is_j     = 1'b0;
`endif
    is_illegal = !(is_mem || is_rtype || is_beq || is_j);
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM of the multi-cycle MIPS datapath.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset (forces IDLE)
//   bus     - mips_multicycle_control_if.master: opcode/mem_ready in,
//             all datapath controls, ALUop, illegal_op and state out
// Outputs are Moore decodes of the state, except IRWrite/PCWrite in FETCH
// which are qualified by mem_ready so the PC advances exactly once.
// Configuration: define MIPS_JUMP_EN to enable the j instruction (JUMP state).
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  mips_multicycle_control_if.master     bus
);

  state_e state_q, state_d;
  logic   is_mem, is_lw, is_rtype, is_beq, is_j, is_illegal;

  mips_opcode_decode u_decode (
    .opcode     (bus.opcode),
    .is_mem     (is_mem),
    .is_lw      (is_lw),
    .is_rtype   (is_rtype),
    .is_beq     (is_beq),
    .is_j       (is_j),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem)        state_d = S_MEM_ADDR;
        else if (is_rtype) state_d = S_EXECUTE;
        else if (is_beq)   state_d = S_BRANCH;
`ifdef MIPS_JUMP_EN
        else if (is_j)     state_d = S_JUMP;
`else
        else if (is_j)     state_d = S_FETCH;
`endif
        else               state_d = S_FETCH;
      end
      S_MEM_ADDR:  state_d = is_lw ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
`ifdef MIPS_JUMP_EN
      S_JUMP:      state_d = S_FETCH;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.ALUop       = ALUOP_ADD;
    bus.illegal_op  = 1'b0;
    bus.state       = state_q;
    unique case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.illegal_op = is_illegal;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUop   = ALUOP_RTYPE;
      end
      S_R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUop       = ALUOP_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
`ifdef MIPS_JUMP_EN
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,
  //  RegDst,ALUSrcA,PCSource[1:0],ALUSrcB[1:0],ALUop[1:0],illegal_op}
  logic [16:0] ctl;
  assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.RegWrite,
                bus.RegDst, bus.ALUSrcA, bus.PCSource, bus.ALUSrcB,
                bus.ALUop, bus.illegal_op};

  // Hand-written expected control words per state.
  localparam logic [16:0] C_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FETCH   = 17'b1_0_0_1_0_0_1_0_0_0_00_01_00_0;
  localparam logic [16:0] C_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_00_01_00_0;
  localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_0;
  localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_1;
  localparam logic [16:0] C_MADDR   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_MREAD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB     = 17'b0_0_0_0_0_1_0_1_0_0_00_00_00_0;
  localparam logic [16:0] C_MWRITE  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_01_00_01_0;
  localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check state and control word, then advance one clock.
  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [16:0] c);
    #1;
    check({tag, ".state"}, {28'd0, bus.state}, {28'd0, st});
    check({tag, ".ctl"}, {15'd0, ctl}, {15'd0, c});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_LW;

    // Reset held 3 cycles: IDLE, all outputs 0.
    for (int unsigned i = 0; i < 3; i++) expect_cycle("reset", 4'd0, C_ZERO);
    @(negedge clk);
    reset_n = 1'b1;

    // lw with mem_ready=1: 5 cycles.
    expect_cycle("lw.idle",   4'd0, C_ZERO);
    expect_cycle("lw.fetch",  4'd1, C_FETCH);
    expect_cycle("lw.decode", 4'd2, C_DECODE);
    expect_cycle("lw.maddr",  4'd3, C_MADDR);
    expect_cycle("lw.mread",  4'd4, C_MREAD);
    expect_cycle("lw.mwb",    4'd5, C_MWB);

    // FETCH stall 4 cycles, then R-type.
    bus.opcode    = OP_RTYPE;
    bus.mem_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) expect_cycle("stall.fetch", 4'd1, C_FSTALL);
    bus.mem_ready = 1'b1;
    expect_cycle("stall.fetch_go", 4'd1, C_FETCH);
    expect_cycle("r.decode",  4'd2, C_DECODE);
    expect_cycle("r.exec",    4'd7, C_EXEC);
    expect_cycle("r.rwb",     4'd8, C_RWB);

    // beq.
    bus.opcode = OP_BEQ;
    expect_cycle("beq.fetch",  4'd1, C_FETCH);
    expect_cycle("beq.decode", 4'd2, C_DECODE);
    expect_cycle("beq.branch", 4'd9, C_BRANCH);

    // Illegal opcode 001111.
    bus.opcode = 6'b001111;
    expect_cycle("ill.fetch",  4'd1, C_FETCH);
    expect_cycle("ill.decode", 4'd2, C_DEC_ILL);

    // Jump opcode.
    bus.opcode = OP_J;
    expect_cycle("j.fetch", 4'd1, C_FETCH);
`ifdef MIPS_JUMP_EN
    expect_cycle("j.decode", 4'd2, C_DECODE);
    expect_cycle("j.jump",   4'd10, C_JUMP);
`else
    expect_cycle("j.decode_ill", 4'd2, C_DEC_ILL);
`endif

    // lw with a one-cycle MEM_READ stall; mem_ready low in DECODE is ignored.
    bus.opcode = OP_LW;
    expect_cycle("lw2.fetch", 4'd1, C_FETCH);
    bus.mem_ready = 1'b0;
    expect_cycle("lw2.decode", 4'd2, C_DECODE);
    expect_cycle("lw2.maddr",  4'd3, C_MADDR);
    expect_cycle("lw2.mread_stall", 4'd4, C_MREAD);
    bus.mem_ready = 1'b1;
    expect_cycle("lw2.mread", 4'd4, C_MREAD);
    expect_cycle("lw2.mwb",   4'd5, C_MWB);

    // sw with MEM_WRITE stalled, then reset mid-store.
    bus.opcode = OP_SW;
    expect_cycle("sw.fetch",  4'd1, C_FETCH);
    expect_cycle("sw.decode", 4'd2, C_DECODE);
    expect_cycle("sw.maddr",  4'd3, C_MADDR);
    bus.mem_ready = 1'b0;
    expect_cycle("sw.mwrite_stall", 4'd6, C_MWRITE);
    #1;
    check("sw.mwrite_before_rst", {31'd0, bus.MemWrite}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid.memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("rst_mid.state", {28'd0, bus.state}, 32'd0);
    expect_cycle("rst_mid.hold", 4'd0, C_ZERO);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.mem_ready = 1'b1;
    expect_cycle("rst_mid.idle",  4'd0, C_ZERO);
    expect_cycle("rst_mid.fetch", 4'd1, C_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
